// File: rtl/seq_scheduler_pkg.sv
// Shared helpers for the task dispatcher in front of the sequence generator.
// Only width arithmetic lives here; FSM encodings stay local to the scheduler.
// The sequencer's opcodes are deliberately not referenced, only its stop output.
package seq_scheduler_pkg;

    // Width of a saturating counter that must represent 0..limit (never zero bits).
    function automatic int unsigned sat_cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

    // Width of an occupancy counter for a queue of 'depth' entries (0..depth).
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_queue.sv
// Circular buffer of task start addresses with head/tail pointers and occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; caller gates on count.
module seq_queue
    import seq_scheduler_pkg::*;
#(
    parameter int AW = 7,
    parameter int QD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [AW-1:0]            i_push_dat,
    input  logic                     i_pop,
    output logic [AW-1:0]            o_head_dat,
    output logic [occ_width(QD)-1:0] o_count
);
    localparam int PW = $clog2(QD);
    localparam int OW = occ_width(QD);
    localparam logic [OW-1:0] QD_W = OW'(QD);

    logic [AW-1:0] r_mem [QD];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [OW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count != QD_W);
    assign w_pop  = i_pop && (r_count != '0);

    // Entry storage; no reset needed since only counted entries are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_head];
    assign o_count    = r_count;

endmodule

// File: rtl/seq_scheduler.sv
// Dispatches queued start addresses to the sequencer as one-cycle jumps and tracks each task to STOP.
// Latency: request accepted at edge E into an empty queue with stop high -> jump high after edge E+1.
// Backpressure: req_ready drops only when the queue is full (or in reset); running tasks never stall intake.
module seq_scheduler
    import seq_scheduler_pkg::*;
#(
    parameter int aw  = 7,
    parameter int qd  = 4,
    parameter int tmo = 0,
    parameter int cw  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [aw-1:0]            req_addr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     stop,
    output logic [aw-1:0]            addr,
    output logic                     jump,
    output logic                     busy,
    output logic                     done,
    output logic [cw-1:0]            done_count,
    output logic                     timeout,
    output logic [occ_width(qd)-1:0] pending
);
    localparam int OW  = occ_width(qd);
    localparam int WDW = sat_cnt_width(tmo);
    localparam logic [OW-1:0]  QD_W  = OW'(qd);
    localparam logic [WDW-1:0] TMO_W = WDW'(tmo);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [aw-1:0]  r_addr;
    logic           r_jump;
    logic           r_done;
    logic [cw-1:0]  r_done_count;
    logic           r_timeout;
    logic [WDW-1:0] r_wd;

    logic [aw-1:0]  w_addr_nxt;
    logic           w_jump_nxt;
    logic           w_done_nxt;
    logic [cw-1:0]  w_done_count_nxt;
    logic           w_timeout_nxt;
    logic [WDW-1:0] w_wd_nxt;

    logic [OW-1:0]  w_pending;
    logic [aw-1:0]  w_head;
    logic           w_push;
    logic           w_pop;

    assign req_ready = (w_pending != QD_W) && !rst;
    assign w_push    = req_valid && req_ready;

    seq_queue #(
        .AW (aw),
        .QD (qd)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (req_addr),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_pending)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: launch only when the sequencer is parked at STOP; LAUNCH lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((w_pending != '0) && stop) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values: issue the jump, count completions, run the watchdog.
    always_comb begin
        w_pop            = 1'b0;
        w_addr_nxt       = r_addr;
        w_jump_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_done_count_nxt = r_done_count;
        w_timeout_nxt    = r_timeout;
        w_wd_nxt         = r_wd;
        case (r_state)
            S_IDLE: begin
                if ((w_pending != '0) && stop) begin
                    w_pop      = 1'b1;
                    w_addr_nxt = w_head;
                    w_jump_nxt = 1'b1;
                end
            end
            S_LAUNCH: begin
                // stop now reflects the opcode at the jump target
                if (stop) begin
                    w_done_nxt       = 1'b1;
                    w_done_count_nxt = r_done_count + 1'b1;
                end else begin
                    w_wd_nxt = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_done_nxt       = 1'b1;
                    w_done_count_nxt = r_done_count + 1'b1;
                end else begin
                    w_wd_nxt = (r_wd == TMO_W) ? r_wd : r_wd + 1'b1;
                    // the sequencer cannot be aborted, so a timeout is only flagged
                    if ((tmo != 0) && (w_wd_nxt == TMO_W)) begin
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_jump       <= 1'b0;
            r_done       <= 1'b0;
            r_done_count <= '0;
            r_timeout    <= 1'b0;
            r_wd         <= '0;
        end else begin
            r_addr       <= w_addr_nxt;
            r_jump       <= w_jump_nxt;
            r_done       <= w_done_nxt;
            r_done_count <= w_done_count_nxt;
            r_timeout    <= w_timeout_nxt;
            r_wd         <= w_wd_nxt;
        end
    end

    assign addr       = r_addr;
    assign jump       = r_jump;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign done_count = r_done_count;
    assign timeout    = r_timeout;
    assign pending    = w_pending;

endmodule

// File: tb/tb_seq_scheduler.sv
// Directed bench for seq_scheduler with qd=4, tmo=8, cw=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seq_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] req_addr;
    logic       req_valid;
    logic       req_ready;
    logic       stop;
    logic [6:0] addr;
    logic       jump;
    logic       busy;
    logic       done;
    logic [7:0] done_count;
    logic       timeout;
    logic [2:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    seq_scheduler #(
        .aw  (7),
        .qd  (4),
        .tmo (8),
        .cw  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_addr   (req_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .stop       (stop),
        .addr       (addr),
        .jump       (jump),
        .busy       (busy),
        .done       (done),
        .done_count (done_count),
        .timeout    (timeout),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; stop = 1'b1;
        tick(); tick();
        n_cmp++; if (jump !== 1'b0) begin n_err++; $display("FAIL rst_jump: got %0b want 0", jump); end
        n_cmp++; if (addr !== 7'h00) begin n_err++; $display("FAIL rst_addr: got %0h want 0", addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (done_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", done_count); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
        n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL rst_pending: got %0d want 0", pending); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_reset: got %0b want 0", req_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %0b want 1", req_ready); end
    endtask

    // Push 0x10 with stop=1, then the task runs 5 cycles before stopping.
    task automatic test_launch_and_run();
        req_valid = 1'b1; req_addr = 7'h10;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (pending !== 3'd1) begin n_err++; $display("FAIL launch_pending: got %0d want 1", pending); end
        n_cmp++; if (jump !== 1'b0) begin n_err++; $display("FAIL launch_early_jump: got %0b want 0", jump); end
        tick();
        n_cmp++; if (jump !== 1'b1) begin n_err++; $display("FAIL launch_jump: got %0b want 1", jump); end
        n_cmp++; if (addr !== 7'h10) begin n_err++; $display("FAIL launch_addr: got %0h want 10", addr); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL launch_busy: got %0b want 1", busy); end
        n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL launch_pop: got %0d want 0", pending); end
        stop = 1'b0;
        tick();
        n_cmp++; if (jump !== 1'b0) begin n_err++; $display("FAIL launch_jump_width: got %0b want 0", jump); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL run_early_done: got %0b want 0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy: got %0b want 1", busy); end
        stop = 1'b1;
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL run_done: got %0b want 1", done); end
        n_cmp++; if (done_count !== 8'd1) begin n_err++; $display("FAIL run_count: got %0d want 1", done_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_idle: got %0b want 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL run_done_pulse: got %0b want 0", done); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL run_no_timeout: got %0b want 0", timeout); end
    endtask

    // Target is itself STOP: done one cycle after the jump, no RUN.
    task automatic test_empty_task();
        req_valid = 1'b1; req_addr = 7'h22;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (jump !== 1'b1 || addr !== 7'h22) begin n_err++; $display("FAIL empty_jump: got %0b/%0h want 1/22", jump, addr); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL empty_done: got %0b want 1", done); end
        n_cmp++; if (done_count !== 8'd2) begin n_err++; $display("FAIL empty_count: got %0d want 2", done_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_busy: got %0b want 0", busy); end
        n_cmp++; if (jump !== 1'b0) begin n_err++; $display("FAIL empty_jump_low: got %0b want 0", jump); end
    endtask

    // Five pushes with stop=0: four accepted, then FIFO-order launches every two cycles.
    task automatic test_queue_full();
        logic [6:0] base;
        base = 7'h31;
        stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = base + 7'(i);
            #1;
            n_cmp++;
            if (req_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready_%0d: got %0b want %0b", i, req_ready, (i < 4)); end
            tick();
        end
        req_valid = 1'b0;
        n_cmp++; if (pending !== 3'd4) begin n_err++; $display("FAIL full_pending: got %0d want 4", pending); end
        n_cmp++; if (jump !== 1'b0) begin n_err++; $display("FAIL full_no_jump_while_run: got %0b want 0", jump); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy: got %0b want 0", busy); end
        stop = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_at_pop: got %0b want 0", req_ready); end
        tick();
        n_cmp++; if (jump !== 1'b1 || addr !== 7'h31) begin n_err++; $display("FAIL order_0: got %0b/%0h want 1/31", jump, addr); end
        n_cmp++; if (pending !== 3'd3) begin n_err++; $display("FAIL order_pending: got %0d want 3", pending); end
        for (int k = 1; k < 4; k++) begin
            tick();
            n_cmp++; if (jump !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL b2b_gap_%0d: jump %0b done %0b want 0/1", k, jump, done); end
            tick();
            n_cmp++; if (jump !== 1'b1 || addr !== (base + 7'(k))) begin n_err++; $display("FAIL order_%0d: got %0b/%0h want 1/%0h", k, jump, addr, base + 7'(k)); end
        end
        tick();
        n_cmp++; if (done_count !== 8'd6) begin n_err++; $display("FAIL full_count: got %0d want 6", done_count); end
        tick();
        n_cmp++; if (jump !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL full_drained: jump %0b busy %0b want 0/0", jump, busy); end
    endtask

    // Watchdog with tmo=8; a request arriving during RUN is accepted without a bubble.
    task automatic test_timeout();
        req_valid = 1'b1; req_addr = 7'h40;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (jump !== 1'b1 || addr !== 7'h40) begin n_err++; $display("FAIL tmo_jump: got %0b/%0h want 1/40", jump, addr); end
        stop = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %0b want 0 after 7 RUN cycles", timeout); end
        req_valid = 1'b1; req_addr = 7'h41;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL run_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_set: got %0b want 1 after 8 RUN cycles", timeout); end
        n_cmp++; if (pending !== 3'd1) begin n_err++; $display("FAIL run_push: got %0d want 1", pending); end
        for (int i = 0; i < 11; i++) tick();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL tmo_still_run: busy %0b done %0b want 1/0", busy, done); end
        stop = 1'b1;
        tick();
        n_cmp++; if (done !== 1'b1 || done_count !== 8'd7) begin n_err++; $display("FAIL tmo_done: got %0b/%0d want 1/7", done, done_count); end
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %0b want 1", timeout); end
        tick();
        n_cmp++; if (jump !== 1'b1 || addr !== 7'h41) begin n_err++; $display("FAIL after_done_jump: got %0b/%0h want 1/41", jump, addr); end
    endtask

    // Reset while a task runs with two entries queued.
    task automatic test_reset_mid_run();
        stop = 1'b0;
        req_valid = 1'b1; req_addr = 7'h50;
        tick();
        req_addr = 7'h51;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (pending !== 3'd2 || busy !== 1'b1) begin n_err++; $display("FAIL mid_setup: pending %0d busy %0b want 2/1", pending, busy); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %0b want 0", busy); end
        n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL arst_pending: got %0d want 0", pending); end
        n_cmp++; if (done_count !== 8'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", done_count); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL arst_timeout: got %0b want 0", timeout); end
        n_cmp++; if (jump !== 1'b0 || addr !== 7'h00 || done !== 1'b0) begin n_err++; $display("FAIL arst_outs: jump %0b addr %0h done %0b want 0/0/0", jump, addr, done); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL arst_ready: got %0b want 0", req_ready); end
        #2;
        rst = 1'b0;
        tick(); tick();
        stop = 1'b1;
        tick(); tick();
        n_cmp++; if (jump !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL post_rst_empty: jump %0b busy %0b want 0/0", jump, busy); end
        stop = 1'b0;
        req_valid = 1'b1; req_addr = 7'h60;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (jump !== 1'b0 || pending !== 3'd1) begin n_err++; $display("FAIL post_rst_wait_stop: jump %0b pending %0d want 0/1", jump, pending); end
        stop = 1'b1;
        tick();
        n_cmp++; if (jump !== 1'b1 || addr !== 7'h60) begin n_err++; $display("FAIL post_rst_jump: got %0b/%0h want 1/60", jump, addr); end
        tick();
        n_cmp++; if (done_count !== 8'd1) begin n_err++; $display("FAIL post_rst_count: got %0d want 1", done_count); end
    endtask

    // 255 further empty tasks take done_count from 1 through 255 and wrap to 0.
    task automatic test_count_wrap();
        for (int i = 0; i < 255; i++) begin
            req_valid = 1'b1; req_addr = 7'(i);
            tick();
            req_valid = 1'b0;
            tick();
            tick();
            if (i == 253) begin
                n_cmp++; if (done_count !== 8'd255) begin n_err++; $display("FAIL wrap_max: got %0d want 255", done_count); end
            end
        end
        n_cmp++; if (done_count !== 8'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", done_count); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %0b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_launch_and_run();
        test_empty_task();
        test_queue_full();
        test_timeout();
        test_reset_mid_run();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: bench still running at %0t, want finished", $time);
        $fatal(1, "time limit");
    end

endmodule
